// File: rtl/pc_fetch_unit.sv
// PC and fetch sequencer for the unpipelined MIPS core: FETCH/WAIT/EXEC handshake with imem, PC/EPC update.
// Optional macro PC_ALIGN_CHECK_EN turns misaligned jump/eret targets into exceptions and adds o_badaddr.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_nextpc,
   input  logic [1:0]  i_pcsrc,
   input  logic        i_stall,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_data,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4,
   output logic [31:0] o_instr,
   output logic        o_instr_valid,
   output logic [31:0] o_epc,
`ifdef PC_ALIGN_CHECK_EN
   output logic [31:0] o_badaddr,
`endif
   output logic        o_exc_taken
);

   typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_EXEC} state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] epc_reg, epc_next;
   logic [31:0] instr_reg, instr_next;
   logic        exc_reg, exc_next;
   logic        fetch_en_reg;
   logic        ack_accept;
   logic [31:0] target;
   logic        take_exc;
`ifdef PC_ALIGN_CHECK_EN
   logic [31:0] badaddr_reg, badaddr_next;
   logic        misaligned;
`endif

   // fetch_en_reg keeps the request low for the first cycle after reset so a stale ack is ignored
   assign o_imem_req    = fetch_en_reg && (state_reg != ST_EXEC);
   assign o_imem_addr   = pc_reg;
   assign o_pc          = pc_reg;
   assign o_pc_plus4    = pc_reg + 32'd4;
   assign o_instr       = instr_reg;
   assign o_instr_valid = (state_reg == ST_EXEC);
   assign o_epc         = epc_reg;
   assign o_exc_taken   = exc_reg;
   assign ack_accept    = o_imem_req && i_imem_ack;
   assign target        = (i_pcsrc == 2'b01) ? i_nextpc : epc_reg;
`ifdef PC_ALIGN_CHECK_EN
   assign o_badaddr     = badaddr_reg;
   assign misaligned    = (i_pcsrc[1] ^ i_pcsrc[0]) && (target[1:0] != 2'b00);
   assign take_exc      = (i_pcsrc == 2'b11) || misaligned;
`else
   assign take_exc      = (i_pcsrc == 2'b11);
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg    <= ST_FETCH;
         pc_reg       <= RESET_VECTOR;
         epc_reg      <= 32'd0;
         instr_reg    <= 32'd0;
         exc_reg      <= 1'b0;
         fetch_en_reg <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
         badaddr_reg  <= 32'd0;
`endif
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         epc_reg      <= epc_next;
         instr_reg    <= instr_next;
         exc_reg      <= exc_next;
         fetch_en_reg <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
         badaddr_reg  <= badaddr_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      epc_next     = epc_reg;
      instr_next   = instr_reg;
      exc_next     = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      badaddr_next = badaddr_reg;
`endif
      case (state_reg)
         ST_FETCH: begin
            // an ack in the very first request cycle skips WAIT entirely
            if (ack_accept) begin
               instr_next = i_imem_data;
               state_next = ST_EXEC;
            end else if (fetch_en_reg) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ack_accept) begin
               instr_next = i_imem_data;
               state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!i_stall) begin
               state_next = ST_FETCH;
               if (take_exc) begin
                  pc_next  = EXC_VECTOR;
                  epc_next = pc_reg;
                  exc_next = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                  if (misaligned) badaddr_next = target;
`endif
               end else if (i_pcsrc == 2'b00) begin
                  pc_next = o_pc_plus4;
               end else begin
                  pc_next = target;
               end
            end
         end
         default: state_next = ST_FETCH;
      endcase
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: architectural model (PC/EPC/instr) checked every cycle plus literal pins.
module tb_pc_fetch_unit;
   localparam logic [31:0] RST_VEC = 32'h0000_0000;
   localparam logic [31:0] EXC_VEC = 32'h0000_0180;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [31:0] i_nextpc;
   logic [1:0]  i_pcsrc;
   logic        i_stall;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_data;
   logic [31:0] o_pc;
   logic [31:0] o_pc_plus4;
   logic [31:0] o_instr;
   logic        o_instr_valid;
   logic [31:0] o_epc;
   logic        o_exc_taken;
`ifdef PC_ALIGN_CHECK_EN
   logic [31:0] o_badaddr;
`endif

   int checks = 0;
   int errors = 0;

   // architectural model
   logic [31:0] m_pc = RST_VEC;
   logic [31:0] m_epc = 32'd0;
   logic [31:0] m_instr = 32'd0;
   logic [31:0] m_bad = 32'd0;
   bit          m_exc = 1'b0;

   pc_fetch_unit #(.RESET_VECTOR(RST_VEC), .EXC_VECTOR(EXC_VEC)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_nextpc(i_nextpc), .i_pcsrc(i_pcsrc),
      .i_stall(i_stall), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data), .o_pc(o_pc),
      .o_pc_plus4(o_pc_plus4), .o_instr(o_instr), .o_instr_valid(o_instr_valid),
      .o_epc(o_epc),
`ifdef PC_ALIGN_CHECK_EN
      .o_badaddr(o_badaddr),
`endif
      .o_exc_taken(o_exc_taken)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // per-cycle comparison against the model
   always @(negedge i_clk) begin
      if (i_rst_n) begin
         if (o_imem_req) check("fetch_addr", o_imem_addr, m_pc);
         check("pc", o_pc, m_pc);
         check("pc_plus4", o_pc_plus4, m_pc + 32'd4);
         check("epc", o_epc, m_epc);
         if (o_instr_valid) check("instr", o_instr, m_instr);
         check("exc_taken", {31'b0, o_exc_taken}, {31'b0, m_exc});
`ifdef PC_ALIGN_CHECK_EN
         check("badaddr", o_badaddr, m_bad);
`endif
         m_exc = 1'b0;
      end
   end

   task automatic model_retire(input logic [1:0] src, input logic [31:0] tgt);
      logic [31:0] dest;
      bit          exc;
      exc  = 1'b0;
      dest = 32'd0;
      case (src)
         2'b00:   dest = m_pc + 32'd4;
         2'b01:   dest = tgt;
         2'b10:   dest = m_epc;
         default: exc = 1'b1;
      endcase
`ifdef PC_ALIGN_CHECK_EN
      if (!exc && src != 2'b00 && dest[1:0] != 2'b00) begin
         exc   = 1'b1;
         m_bad = dest;
      end
`endif
      if (exc) begin
         m_epc = m_pc;
         m_pc  = EXC_VEC;
         m_exc = 1'b1;
      end else begin
         m_pc = dest;
      end
   endtask

   // one instruction: wait for req, ack after 'dly' cycles, stall 'stl' cycles, retire with src/tgt
   task automatic do_instr(input int dly, input int stl, input logic [1:0] src,
                           input logic [31:0] tgt, input logic [31:0] data);
      int n;
      n = 0;
      while (!o_imem_req && n < 40) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_imem_req) begin
         check("req_timeout", 32'd0, 32'd1);
         return;
      end
      repeat (dly) @(negedge i_clk);
      i_imem_ack  = 1'b1;
      i_imem_data = data;
      m_instr     = data;
      @(negedge i_clk);
      i_imem_ack  = 1'b0;
      i_imem_data = $urandom;
      check("valid_after_ack", {31'b0, o_instr_valid}, 32'd1);
      if (stl > 0) begin
         i_stall = 1'b1;
         repeat (stl) begin
            @(negedge i_clk);
            check("valid_in_stall", {31'b0, o_instr_valid}, 32'd1);
         end
      end
      i_stall  = 1'b0;
      i_pcsrc  = src;
      i_nextpc = tgt;
      @(posedge i_clk);
      model_retire(src, tgt);
      @(negedge i_clk);
      i_pcsrc  = 2'($urandom);
      i_nextpc = $urandom;
      check("valid_after_retire", {31'b0, o_instr_valid}, 32'd0);
      $display("instr pc->%h epc=%h instr=%h exc=%0d", o_pc, o_epc, o_instr, o_exc_taken);
   endtask

   initial begin
      int n;
      i_rst_n = 1'b0; i_nextpc = 32'hDEAD_BEEF; i_pcsrc = 2'b11; i_stall = 1'b0;
      i_imem_ack = 1'b0; i_imem_data = 32'h1234_5678;
      repeat (3) @(negedge i_clk);
      check("rst_pc", o_pc, 32'h0000_0000);
      check("rst_epc", o_epc, 32'd0);
      check("rst_instr", o_instr, 32'd0);
      check("rst_valid", {31'b0, o_instr_valid}, 32'd0);
      check("rst_req", {31'b0, o_imem_req}, 32'd0);
      check("rst_exc", {31'b0, o_exc_taken}, 32'd0);
      i_rst_n = 1'b1;

      n = 0;
      while (!o_imem_req && n < 10) begin @(negedge i_clk); n++; end
      check("first_addr", o_imem_addr, 32'h0000_0000);
      do_instr(1, 0, 2'b00, 32'h0, 32'hA000_0001);
      check("lit_addr4", o_imem_addr, 32'h0000_0004);
      do_instr(0, 0, 2'b01, 32'h0000_0040, 32'hA000_0002);
      check("lit_pc40", o_pc, 32'h0000_0040);
      do_instr(1, 0, 2'b01, 32'h0000_0100, 32'hA000_0003);
      check("lit_addr100", o_imem_addr, 32'h0000_0100);
      check("lit_epc0", o_epc, 32'h0000_0000);
      do_instr(2, 0, 2'b01, 32'h0000_0200, 32'hA000_0004);
      do_instr(1, 0, 2'b11, 32'h5555_5555, 32'hA000_0005);
      check("lit_exc_pc", o_pc, 32'h0000_0180);
      check("lit_exc_epc", o_epc, 32'h0000_0200);
      check("lit_exc_pulse", {31'b0, o_exc_taken}, 32'd1);
      do_instr(1, 0, 2'b10, 32'h5555_5555, 32'hA000_0006);
      check("lit_eret_pc", o_pc, 32'h0000_0200);
      do_instr(5, 4, 2'b01, 32'hFFFF_FFFC, 32'hA000_0007);
      check("lit_pc_top", o_pc, 32'hFFFF_FFFC);
      do_instr(1, 0, 2'b00, 32'h0, 32'hA000_0008);
      check("lit_wrap", o_pc, 32'h0000_0000);
      do_instr(1, 2, 2'b01, 32'h0000_0102, 32'hA000_0009);
`ifdef PC_ALIGN_CHECK_EN
      check("lit_align_pc", o_pc, 32'h0000_0180);
      check("lit_badaddr", o_badaddr, 32'h0000_0102);
      check("lit_align_pulse", {31'b0, o_exc_taken}, 32'd1);
`else
      check("lit_noalign_pc", o_pc, 32'h0000_0102);
`endif
      do_instr(1, 0, 2'b01, 32'h0000_0300, 32'hA000_000A);
      do_instr(0, 1, 2'b10, 32'h0, 32'hA000_000B);

      // reset pulsed during WAIT, then a late ack in the unarmed FETCH cycle
      n = 0;
      while (!o_imem_req && n < 10) begin @(negedge i_clk); n++; end
      @(negedge i_clk);
      i_rst_n = 1'b0;
      m_pc = RST_VEC; m_epc = 32'd0; m_instr = 32'd0; m_bad = 32'd0; m_exc = 1'b0;
      #1;
      check("rst_req_drop", {31'b0, o_imem_req}, 32'd0);
      check("rst_pc_async", o_pc, 32'h0000_0000);
      @(negedge i_clk);
      i_rst_n     = 1'b1;
      i_imem_ack  = 1'b1;
      i_imem_data = 32'hBAD0_BAD0;
      @(negedge i_clk);
      i_imem_ack  = 1'b0;
      check("late_ack_valid", {31'b0, o_instr_valid}, 32'd0);
      check("late_ack_instr", o_instr, 32'd0);
      do_instr(1, 0, 2'b00, 32'h0, 32'hA000_000C);
      check("lit_post_rst", o_pc, 32'h0000_0004);

      repeat (2) @(negedge i_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
